// File: rtl/led_cnt_multi.sv
// led_cnt_multi: NCH independent LED rate channels with
// per-channel edge interrupts and a shared masked IRQ.
module led_cnt_multi #(
  parameter int NCH     = 4,
  parameter int CNT_1S  = 100_000_000,
  parameter int DIV_W   = 5,
  parameter int DIV_MAX = 20,
  parameter int CW      = 28,
  parameter int INT_W   = 11
) (
  input  logic                 clk100,
  input  logic                 rst_n,
  input  logic [NCH*DIV_W-1:0] div_i,
  input  logic [NCH*2-1:0]     mode_i,
  input  logic [NCH-1:0]       wren_i,
  input  logic [NCH-1:0]       int_en_i,
  input  logic [NCH-1:0]       int_clr_i,
  output logic [NCH-1:0]       led_o,
  output logic [NCH-1:0]       led_int_o,
  output logic [NCH-1:0]       int_sts_o,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    M_OFF  = 2'b00,
    M_TOG  = 2'b01,
    M_ONE  = 2'b10,
    M_HOLD = 2'b11
  } mode_e;

  localparam int IW = $clog2(INT_W + 1);
  localparam int NT = 2**DIV_W;

  // Terminal counts per divider code, fixed at elaboration.
  logic [CW-1:0] max_tab [NT];

  for (genvar i = 0; i < NT; i++) begin : g_tab
    localparam int D = (i == 0 || i > DIV_MAX) ? 1 : i;
    assign max_tab[i] = CW'(CNT_1S / D - 1);
  end

  logic [NCH-1:0] sts_v;
  logic           irq_q;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [DIV_W-1:0] div_sh_q;
    mode_e            mode_q;
    mode_e            mode_p_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_max;
    logic             led_q;
    logic             led_dly_q;
    logic             run_q;
    logic             sts_q;
    logic [IW-1:0]    ic_q;
    logic             tc;
    logic             wr;
    logic             chg;
    logic             rise;

    assign cnt_max = max_tab[div_sh_q];
    assign tc      = cnt_q == cnt_max;
    assign wr      = wren_i[k];
    assign chg     = mode_q != mode_p_q;
    assign rise    = led_q & ~led_dly_q;

    always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
        div_sh_q  <= '0;
        mode_q    <= M_OFF;
        mode_p_q  <= M_OFF;
        cnt_q     <= '0;
        led_q     <= 1'b0;
        led_dly_q <= 1'b0;
        run_q     <= 1'b0;
        sts_q     <= 1'b0;
        ic_q      <= '0;
      end else begin
        mode_q    <= mode_e'(mode_i[2*k +: 2]);
        mode_p_q  <= mode_q;
        led_dly_q <= led_q;
        if (tc || wr)
          div_sh_q <= div_i[k*DIV_W +: DIV_W];

        if (chg) begin
          cnt_q <= '0;
          run_q <= 1'b0;
          unique case (mode_q)
            M_OFF:  led_q <= 1'b0;
            M_ONE:  led_q <= 1'b0;
            M_HOLD: led_q <= 1'b1;
            M_TOG:  ;
          endcase
        end else begin
          unique case (mode_q)
            M_OFF: begin
              cnt_q <= '0;
              led_q <= 1'b0;
            end
            M_HOLD: begin
              cnt_q <= '0;
              led_q <= 1'b1;
            end
            M_TOG: begin
              if (wr || tc) begin
                cnt_q <= '0;
                led_q <= ~led_q;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
            M_ONE: begin
              // Restart in RUN keeps led high for a fresh full period.
              if (!run_q) begin
                cnt_q <= '0;
                led_q <= wr;
                run_q <= wr;
              end else if (wr) begin
                cnt_q <= '0;
              end else if (tc) begin
                cnt_q <= '0;
                led_q <= 1'b0;
                run_q <= 1'b0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end
          endcase
        end

        if (rise)
          ic_q <= IW'(INT_W);
        else if (ic_q != '0)
          ic_q <= ic_q - IW'(1);

        if (rise)
          sts_q <= 1'b1;
        else if (int_clr_i[k])
          sts_q <= 1'b0;
      end
    end

    assign led_o[k]     = led_q;
    assign led_int_o[k] = ic_q != '0;
    assign sts_v[k]     = sts_q;
  end

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)
      irq_q <= 1'b0;
    else
      irq_q <= |(sts_v & int_en_i);
  end

  assign int_sts_o = sts_v;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_led_cnt_multi.sv
// tb_led_cnt_multi: scoreboard bench for led_cnt_multi
// with NCH=2, CNT_1S=1000, INT_W=11.
module tb_led_cnt_multi;

  localparam int NCH = 2;
  localparam int DW  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*DW-1:0] div_i = '0;
  logic [NCH*2-1:0]  mode_i = '0;
  logic [NCH-1:0]    wren_i = '0;
  logic [NCH-1:0]    int_en_i = '0;
  logic [NCH-1:0]    int_clr_i = '0;
  logic [NCH-1:0]    led_o;
  logic [NCH-1:0]    led_int_o;
  logic [NCH-1:0]    int_sts_o;
  logic              irq_o;

  int cyc = 0;
  int errs = 0;
  int nchk = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sbq[$];

  led_cnt_multi #(
    .NCH(NCH),
    .CNT_1S(1000),
    .DIV_W(DW),
    .DIV_MAX(20),
    .CW(28),
    .INT_W(11)
  ) dut (
    .clk100(clk),
    .rst_n(rst_n),
    .div_i(div_i),
    .mode_i(mode_i),
    .wren_i(wren_i),
    .int_en_i(int_en_i),
    .int_clr_i(int_clr_i),
    .led_o(led_o),
    .led_int_o(led_int_o),
    .int_sts_o(int_sts_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input int obs);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  task automatic set_div(input int ch, input int v);
    logic [DW-1:0] b;
    b = DW'(v);
    div_i[ch*DW +: DW] = b;
  endtask

  task automatic set_mode(input int ch, input int m);
    logic [1:0] b;
    b = 2'(m);
    mode_i[ch*2 +: 2] = b;
  endtask

  task automatic pulse_wren(input int ch);
    wren_i[ch] = 1'b1;
    @(negedge clk);
    wren_i[ch] = 1'b0;
  endtask

  task automatic wait_edge(input int ch, input int max, output int t);
    logic v;
    v = led_o[ch];
    t = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (led_o[ch] !== v) begin
        t = cyc;
        break;
      end
    end
  endtask

  task automatic per(input int ch, input string tag,
                     input int exp, inout int tp);
    int t;
    push(tag, exp);
    wait_edge(ch, exp + 200, t);
    pop_cmp((t < 0) ? -1 : t - tp);
    tp = t;
  endtask

  initial begin
    int   cs, tp, t, n, first, bad;
    logic v, s1, i1, i2;

    repeat (3) @(negedge clk);
    push("rst_led", 0);
    push("rst_int", 0);
    push("rst_sts", 0);
    push("rst_irq", 0);
    pop_cmp(int'(led_o));
    pop_cmp(int'(led_int_o));
    pop_cmp(int'(int_sts_o));
    pop_cmp(int'(irq_o));
    rst_n = 1'b1;
    @(negedge clk);

    cs = cyc;
    set_mode(0, 1);
    push("tog_first", 1002);
    wait_edge(0, 1100, t);
    pop_cmp(t - cs);
    tp = t;
    push("tog_lvl", 1);
    pop_cmp(int'(led_o[0]));
    per(0, "tog_p0", 1000, tp);
    per(0, "tog_p1", 1000, tp);

    set_div(0, 4);
    wait_edge(0, 1100, tp);
    per(0, "div4_a", 250, tp);
    per(0, "div4_b", 250, tp);
    set_div(0, 21);
    wait_edge(0, 300, tp);
    per(0, "div21", 1000, tp);
    set_div(0, 3);
    wait_edge(0, 1100, tp);
    per(0, "div3_a", 333, tp);
    per(0, "div3_b", 333, tp);

    set_div(0, 1);
    wait_edge(0, 400, tp);
    per(0, "div1", 1000, tp);
    repeat (400) @(negedge clk);
    set_div(0, 2);
    per(0, "upd_cur", 1000, tp);
    per(0, "upd_next", 500, tp);

    set_div(0, 0);
    wait_edge(0, 600, tp);
    repeat (100) @(negedge clk);
    v = led_o[0];
    cs = cyc;
    push("wr_tog", 1);
    push("wr_tog_t", 1);
    pulse_wren(0);
    pop_cmp(int'(led_o[0] != v));
    pop_cmp(cyc - cs);
    tp = cyc;
    per(0, "wr_next", 1000, tp);
    repeat (999) @(negedge clk);
    v = led_o[0];
    push("wr_tc_tog", 1);
    pulse_wren(0);
    tp = cyc;
    pop_cmp(int'(led_o[0] != v));
    per(0, "wr_tc_next", 1000, tp);

    push("sts0", 1);
    push("irq_en0", 0);
    pop_cmp(int'(int_sts_o[0]));
    pop_cmp(int'(irq_o));

    int_en_i[1] = 1'b1;
    set_mode(1, 2);
    repeat (3) @(negedge clk);
    push("os_led", 1);
    push("int_pre", 0);
    pulse_wren(1);
    tp = cyc;
    pop_cmp(int'(led_o[1]));
    pop_cmp(int'(led_int_o[1]));
    push("int_first", 1);
    push("int_len", 11);
    push("sts_set", 1);
    push("irq_lag", 0);
    push("irq_on", 1);
    n = 0;
    first = 0;
    s1 = 1'b0;
    i1 = 1'b0;
    i2 = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      if (led_int_o[1]) begin
        n++;
        if (first == 0) first = i;
      end
      if (i == 1) begin
        s1 = int_sts_o[1];
        i1 = irq_o;
      end
      if (i == 2) i2 = irq_o;
    end
    pop_cmp(first);
    pop_cmp(n);
    pop_cmp(int'(s1));
    pop_cmp(int'(i1));
    pop_cmp(int'(i2));
    per(1, "os_len", 1000, tp);
    push("os_stay", -1);
    wait_edge(1, 1500, t);
    pop_cmp(t);

    push("clr_sts", 0);
    push("clr_irq", 0);
    int_clr_i[1] = 1'b1;
    @(negedge clk);
    int_clr_i[1] = 1'b0;
    pop_cmp(int'(int_sts_o[1]));
    @(negedge clk);
    pop_cmp(int'(irq_o));
    push("clr_rise", 1);
    pulse_wren(1);
    int_clr_i[1] = 1'b1;
    @(negedge clk);
    int_clr_i[1] = 1'b0;
    pop_cmp(int'(int_sts_o[1]));
    repeat (598) @(negedge clk);
    push("os_rst_led", 1);
    pulse_wren(1);
    tp = cyc;
    pop_cmp(int'(led_o[1]));
    per(1, "os_restart", 1000, tp);
    push("irq_on2", 1);
    pop_cmp(int'(irq_o));
    push("mask_irq", 0);
    int_en_i[1] = 1'b0;
    @(negedge clk);
    pop_cmp(int'(irq_o));

    set_mode(1, 3);
    push("hold_led", 1);
    repeat (3) @(negedge clk);
    pop_cmp(int'(led_o[1]));
    int_clr_i[1] = 1'b1;
    @(negedge clk);
    int_clr_i[1] = 1'b0;
    pulse_wren(1);
    repeat (12) @(negedge clk);
    push("hold_quiet", 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (led_o[1] !== 1'b1 || led_int_o[1] !== 1'b0 ||
          int_sts_o[1] !== 1'b0)
        bad++;
    end
    pop_cmp(bad);

    set_mode(1, 0);
    push("off_led", 0);
    repeat (3) @(negedge clk);
    pop_cmp(int'(led_o[1]));
    wait_edge(0, 1100, tp);
    per(0, "ch0_indep", 1000, tp);

    set_mode(1, 3);
    int_en_i = 2'b11;
    push("pre_rst_led1", 1);
    push("pre_rst_irq", 1);
    repeat (3) @(negedge clk);
    pop_cmp(int'(led_o[1]));
    pop_cmp(int'(irq_o));
    push("rst_async", 0);
    #2;
    rst_n = 1'b0;
    #1;
    pop_cmp(int'({led_o, led_int_o, int_sts_o, irq_o}));

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
